// File: rtl/row_byte_packer.sv
// -----------------------------------------------------------------------------
// row_byte_packer
//
// Packs a little-endian byte stream into WordW-bit row words. Each finished word
// goes to the row loader over a valid/ready handshake. One run carries exactly
// Dim*Dim words. After the last word the block reports done and accepts no more
// input. An assembly register and an output register let the next word assemble
// while the previous one waits downstream.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   byte_i      input byte
//   byte_v_i    byte_i valid
//   byte_r_o    ready for a byte (registered, from state only)
//   bit_o       assembled row word
//   bit_v_o     bit_o valid
//   bit_r_i     downstream ready
//   last_o      bit_o is the final word of the run
//   done_o      every word of the run has transferred (sticky)
//   pad_err_o   a pad bit of some final byte was nonzero (sticky)
//   word_cnt_o  words transferred downstream (saturating)
// -----------------------------------------------------------------------------
module row_byte_packer #(
    parameter int WordW = 77,
    parameter int ByteW = 8,
    parameter int Dim   = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [ByteW-1:0]                 byte_i,
    input  logic                             byte_v_i,
    output logic                             byte_r_o,
    output logic [WordW-1:0]                 bit_o,
    output logic                             bit_v_o,
    input  logic                             bit_r_i,
    output logic                             last_o,
    output logic                             done_o,
    output logic                             pad_err_o,
    output logic [$clog2(Dim*Dim+1)-1:0]     word_cnt_o
);

    localparam int BPW   = (WordW + ByteW - 1) / ByteW;
    localparam int LoW   = (BPW - 1) * ByteW;        // bits filled by the full bytes
    localparam int PadW  = BPW * ByteW - WordW;      // unused top bits of the final byte
    localparam int Total = Dim * Dim;
    localparam int BcW   = $clog2(BPW);
    localparam int WcW   = $clog2(Total + 1);

    localparam logic [BcW-1:0] BYTE_LAST   = BcW'(BPW - 1);
    localparam logic [BcW-1:0] BYTE_ONE    = BcW'(1);
    localparam logic [BcW-1:0] BYTE_ZERO   = BcW'(0);
    localparam logic [WcW-1:0] WORD_TOTAL  = WcW'(Total);
    localparam logic [WcW-1:0] WORD_PENULT = WcW'(Total - 1);
    localparam logic [WcW-1:0] WORD_ONE    = WcW'(1);

    typedef enum logic [1:0] {
        ST_ASM   = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True when any pad bit of the final byte of a word is set.
    function automatic logic pad_nonzero(input logic [ByteW-1:0] b);
        pad_nonzero = |b[ByteW-1 -: PadW];
    endfunction

    state_e             state_r, state_nxt_s;
    logic [BcW-1:0]     byte_cnt_r, byte_cnt_nxt_s;
    logic [WcW-1:0]     asm_words_r, asm_words_nxt_s;
    logic [WcW-1:0]     word_cnt_r, word_cnt_nxt_s;
    logic [WordW-1:0]   asm_r, asm_nxt_s;
    logic [WordW-1:0]   bit_r, bit_nxt_s;
    logic               bit_v_r, bit_v_nxt_s;
    logic               byte_r_r, byte_r_nxt_s;
    logic               last_r, last_nxt_s;
    logic               done_r, done_nxt_s;
    logic               pad_err_r, pad_err_nxt_s;
    logic               accept_s;
    logic               xfer_s;
    logic               load_s;

    // Next-state, assembly, output-register and counter logic.
    always_comb begin
        accept_s        = byte_r_r && byte_v_i;
        xfer_s          = bit_v_r && bit_r_i;
        load_s          = 1'b0;
        state_nxt_s     = state_r;
        byte_cnt_nxt_s  = byte_cnt_r;
        asm_words_nxt_s = asm_words_r;
        asm_nxt_s       = asm_r;
        pad_err_nxt_s   = pad_err_r;
        bit_nxt_s       = bit_r;
        bit_v_nxt_s     = bit_v_r;
        word_cnt_nxt_s  = word_cnt_r;

        case (state_r)
            ST_ASM: begin
                if (accept_s) begin
                    if (byte_cnt_r == BYTE_LAST) begin
                        // Final byte only contributes its low bits; the rest is pad.
                        asm_nxt_s[WordW-1:LoW] = byte_i[WordW-LoW-1:0];
                        pad_err_nxt_s          = pad_err_r | pad_nonzero(byte_i);
                        byte_cnt_nxt_s         = BYTE_ZERO;
                        asm_words_nxt_s        = asm_words_r + WORD_ONE;
                        state_nxt_s            = ST_FULL;
                    end else begin
                        // Shift right so byte 0 ends up in the least significant lane.
                        asm_nxt_s[LoW-1:0] = {byte_i, asm_r[LoW-1:ByteW]};
                        byte_cnt_nxt_s     = byte_cnt_r + BYTE_ONE;
                    end
                end else begin
                    state_nxt_s = ST_ASM;
                end
            end
            ST_FULL: begin
                // Copy when the output register is free or emptying on this edge.
                load_s = !bit_v_r || bit_r_i;
                if (load_s) begin
                    state_nxt_s = (asm_words_r == WORD_TOTAL) ? ST_DRAIN : ST_ASM;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            ST_DRAIN: begin
                if (xfer_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_ASM;
            end
        endcase

        if (load_s) begin
            bit_nxt_s   = asm_r;
            bit_v_nxt_s = 1'b1;
        end else if (xfer_s) begin
            bit_v_nxt_s = 1'b0;
        end else begin
            bit_v_nxt_s = bit_v_r;
        end

        if (xfer_s && (word_cnt_r != WORD_TOTAL)) begin
            word_cnt_nxt_s = word_cnt_r + WORD_ONE;
        end else begin
            word_cnt_nxt_s = word_cnt_r;
        end

        // Registered copies of the status outputs, computed from next-cycle values.
        done_nxt_s   = done_r | ((state_r == ST_DRAIN) && xfer_s);
        last_nxt_s   = bit_v_nxt_s && (word_cnt_nxt_s == WORD_PENULT);
        byte_r_nxt_s = (state_nxt_s == ST_ASM);
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_ASM;
            byte_cnt_r  <= BYTE_ZERO;
            asm_words_r <= {WcW{1'b0}};
            word_cnt_r  <= {WcW{1'b0}};
            asm_r       <= {WordW{1'b0}};
            bit_r       <= {WordW{1'b0}};
            bit_v_r     <= 1'b0;
            byte_r_r    <= 1'b0;
            last_r      <= 1'b0;
            done_r      <= 1'b0;
            pad_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            byte_cnt_r  <= byte_cnt_nxt_s;
            asm_words_r <= asm_words_nxt_s;
            word_cnt_r  <= word_cnt_nxt_s;
            asm_r       <= asm_nxt_s;
            bit_r       <= bit_nxt_s;
            bit_v_r     <= bit_v_nxt_s;
            byte_r_r    <= byte_r_nxt_s;
            last_r      <= last_nxt_s;
            done_r      <= done_nxt_s;
            pad_err_r   <= pad_err_nxt_s;
        end
    end

    assign byte_r_o   = byte_r_r;
    assign bit_o      = bit_r;
    assign bit_v_o    = bit_v_r;
    assign last_o     = last_r;
    assign done_o     = done_r;
    assign pad_err_o  = pad_err_r;
    assign word_cnt_o = word_cnt_r;

endmodule

// File: tb/tb_row_byte_packer.sv
// -----------------------------------------------------------------------------
// tb_row_byte_packer
//
// Directed bench for row_byte_packer. Accepted bytes build expected words that
// are queued; every downstream transfer pops and compares one. Status outputs
// are compared every cycle against the bench's own counters.
// -----------------------------------------------------------------------------
module tb_row_byte_packer;

    logic        clk_i    = 1'b0;
    logic        rst_ni   = 1'b1;
    logic [7:0]  byte_i   = 8'h00;
    logic        byte_v_i = 1'b0;
    logic        byte_r_o;
    logic [76:0] bit_o;
    logic        bit_v_o;
    logic        bit_r_i  = 1'b0;
    logic        last_o;
    logic        done_o;
    logic        pad_err_o;
    logic [4:0]  word_cnt_o;

    int          tests = 0;
    int          fails = 0;

    logic [76:0] q[$];
    logic [76:0] mword     = '0;
    int          mbc       = 0;
    int          xfer_cnt  = 0;
    logic        exp_pad   = 1'b0;
    logic        prev_hold = 1'b0;
    logic [76:0] prev_bit  = '0;
    logic        acc_flag  = 1'b0;
    logic        rand_r    = 1'b0;
    logic [76:0] exp_single;

    row_byte_packer dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .byte_i     (byte_i),
        .byte_v_i   (byte_v_i),
        .byte_r_o   (byte_r_o),
        .bit_o      (bit_o),
        .bit_v_o    (bit_v_o),
        .bit_r_i    (bit_r_i),
        .last_o     (last_o),
        .done_o     (done_o),
        .pad_err_o  (pad_err_o),
        .word_cnt_o (word_cnt_o)
    );

    always #10 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge: compare status, score transfers, model bytes.
    task automatic monitor();
        logic [76:0] e;
        check("pad_err", 80'(pad_err_o), 80'(exp_pad));
        check("word_cnt", 80'(word_cnt_o), 80'(xfer_cnt));
        check("done", 80'(done_o), 80'(xfer_cnt == 16));
        if (bit_v_o === 1'b1) check("last", 80'(last_o), 80'(xfer_cnt == 15));
        if (prev_hold) begin
            check("hold_v", 80'(bit_v_o), 80'(1'b1));
            check("hold_data", 80'(bit_o), 80'(prev_bit));
        end
        if ((bit_v_o === 1'b1) && bit_r_i) begin
            tests++;
            assert (q.size() > 0) else begin
                fails++;
                $error("FAIL sb_empty: observed word %0h expected none", bit_o);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                check("word", 80'(bit_o), 80'(e));
            end
            xfer_cnt++;
        end
        prev_hold = (bit_v_o === 1'b1) && !bit_r_i;
        prev_bit  = bit_o;
        acc_flag  = 1'b0;
        if (byte_v_i && (byte_r_o === 1'b1)) begin
            acc_flag = 1'b1;
            if (mbc < 9) begin
                mword[8*mbc +: 8] = byte_i;
            end else begin
                mword[76:72] = byte_i[4:0];
                exp_pad      = exp_pad | (|byte_i[7:5]);
            end
            if (mbc == 9) begin
                q.push_back(mword);
                mbc = 0;
            end else begin
                mbc++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
        if (rand_r) bit_r_i = 1'($urandom_range(0, 1));
    endtask

    // Presents one byte and returns after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        logic got;
        n        = 0;
        got      = 1'b0;
        byte_i   = b;
        byte_v_i = 1'b1;
        while (!got && n < 50) begin
            tick();
            got = acc_flag;
            n++;
        end
        if (!got) check("send_timeout", 80'(0), 80'(1));
    endtask

    task automatic wait_words(input int n);
        int k;
        k = 0;
        while (xfer_cnt < n && k < 600) begin
            tick();
            k++;
        end
        check("wait_words", 80'(xfer_cnt), 80'(n));
    endtask

    // Asserts reset between clock edges and checks the outputs clear at once.
    task automatic pulse_reset();
        byte_v_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_byte_r", 80'(byte_r_o), 80'(1'b0));
        check("rst_bit_v", 80'(bit_v_o), 80'(1'b0));
        check("rst_bit", 80'(bit_o), 80'(0));
        check("rst_last", 80'(last_o), 80'(1'b0));
        check("rst_done", 80'(done_o), 80'(1'b0));
        check("rst_pad", 80'(pad_err_o), 80'(1'b0));
        check("rst_word_cnt", 80'(word_cnt_o), 80'(0));
        q.delete();
        mbc       = 0;
        mword     = '0;
        xfer_cnt  = 0;
        exp_pad   = 1'b0;
        prev_hold = 1'b0;
        rand_r    = 1'b0;
        #2;
        rst_ni = 1'b1;
        tick();
        check("rst_release_ready", 80'(byte_r_o), 80'(1'b1));
    endtask

    initial begin
        exp_single = 77'h0A_09_08_07_06_05_04_03_02_01;

        // Reset state
        pulse_reset();

        // Single word, no gaps, downstream always ready
        bit_r_i = 1'b1;
        for (int i = 1; i <= 10; i++) send_byte(8'(i));
        byte_v_i = 1'b0;
        check("single_dead_ready", 80'(byte_r_o), 80'(1'b0));
        check("single_v_early", 80'(bit_v_o), 80'(1'b0));
        tick();
        check("single_ready_back", 80'(byte_r_o), 80'(1'b1));
        check("single_v", 80'(bit_v_o), 80'(1'b1));
        check("single_word_const", 80'(bit_o), 80'(exp_single));
        check("single_pad", 80'(pad_err_o), 80'(1'b0));
        wait_words(1);

        // Backpressure: two words pile up, the 21st byte must wait
        bit_r_i = 1'b0;
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        byte_i   = 8'hEE;
        byte_v_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_ready_low", 80'(byte_r_o), 80'(1'b0));
            check("bp_valid", 80'(bit_v_o), 80'(1'b1));
        end
        byte_v_i = 1'b0;
        bit_r_i  = 1'b1;
        tick();
        check("bp_nogap_v", 80'(bit_v_o), 80'(1'b1));
        check("bp_word1", 80'(bit_o), 80'(q[0]));
        wait_words(3);
        check("bp_empty_after", 80'(bit_v_o), 80'(1'b0));

        // Pad error on final byte, then a clean word
        for (int i = 0; i < 9; i++) send_byte(8'(8'h31 + i));
        send_byte(8'hFF);
        byte_v_i = 1'b0;
        tick();
        check("pad_hi_bits", 80'(bit_o[76:72]), 80'(5'h1F));
        check("pad_flag", 80'(pad_err_o), 80'(1'b1));
        wait_words(4);
        for (int i = 0; i < 10; i++) send_byte(8'(8'h11 + i));
        byte_v_i = 1'b0;
        wait_words(5);
        check("pad_sticky", 80'(pad_err_o), 80'(1'b1));

        // Full run with random gaps and random downstream readiness
        pulse_reset();
        rand_r = 1'b1;
        for (int i = 0; i < 160; i++) begin
            byte_v_i = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            send_byte(8'($urandom));
        end
        byte_v_i = 1'b0;
        rand_r   = 1'b0;
        bit_r_i  = 1'b1;
        wait_words(16);
        tick();
        check("run_done", 80'(done_o), 80'(1'b1));
        check("run_word_cnt", 80'(word_cnt_o), 80'(16));
        check("run_ready_low", 80'(byte_r_o), 80'(1'b0));
        check("run_valid_low", 80'(bit_v_o), 80'(1'b0));
        byte_v_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            byte_i = 8'($urandom);
            tick();
            check("done_ignore_ready", 80'(byte_r_o), 80'(1'b0));
        end
        byte_v_i = 1'b0;
        check("done_ignore_cnt", 80'(word_cnt_o), 80'(16));

        // Async reset mid-word discards the partial bytes
        pulse_reset();
        bit_r_i = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i));
        pulse_reset();
        for (int i = 0; i < 10; i++) send_byte(8'(8'h50 + i));
        byte_v_i = 1'b0;
        wait_words(1);

        // Reset in the middle of a stalled handshake
        bit_r_i = 1'b0;
        for (int i = 0; i < 10; i++) send_byte(8'(8'h60 + i));
        byte_v_i = 1'b0;
        tick();
        tick();
        check("hs_valid_before", 80'(bit_v_o), 80'(1'b1));
        check("hs_cnt_before", 80'(word_cnt_o), 80'(1));
        pulse_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/row_byte_packer.md
# row_byte_packer

Upstream feeder for the global load FSM. Packs a byte stream into 77-bit row words and hands each word to the row loader over a valid/ready handshake. Carries exactly Dim*Dim words per run, then reports done and stops accepting input. One assembly register plus one output register decouple byte arrival from row consumption.

## Interface

Parameters:
- WordW, 77: output word width.
- ByteW, 8: input byte width.
- Dim, 4: array dimension. One run is Dim*Dim words.
- Derived BPW = ceil(WordW/ByteW) = 10: bytes per word.

Ports:
- clk_i  in  1  the single clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- byte_i  in  ByteW  input byte.
- byte_v_i  in  1  byte_i is valid.
- byte_r_o  out  1  block can accept a byte. A byte transfers on a rising edge with byte_v_i && byte_r_o.
- bit_o  out  WordW  assembled row word.
- bit_v_o  out  1  bit_o is valid.
- bit_r_i  in  1  downstream accepts. A word transfers on a rising edge with bit_v_o && bit_r_i.
- last_o  out  1  high while bit_v_o shows the final (Dim*Dim-th) word of the run.
- done_o  out  1  all Dim*Dim words have transferred. Sticky until reset.
- pad_err_o  out  1  sticky flag: a pad bit of some final byte was nonzero.
- word_cnt_o  out  $clog2(Dim*Dim+1)  number of words transferred downstream.

## Operation

- Byte order is little-endian.
  - The k-th accepted byte of a word (k = 0..BPW-1) fills bit_o bits [8k+7:8k].
  - Byte 9 supplies bits [76:72] from its bits [4:0].
  - Bits [7:5] of byte 9 are pad. If any pad bit is nonzero, pad_err_o sets; the word is still emitted unchanged.
- Counters:
  - byte_cnt, 0..BPW-1. Wraps to 0 when the 10th byte is accepted.
  - asm_words, 0..Dim*Dim: words assembled.
  - word_cnt: words transferred downstream.
- State machine (registered state):
  - ASM: byte_r_o = 1. Each accepted byte shifts into the assembly register and increments byte_cnt. When byte BPW-1 is accepted, go to FULL and increment asm_words.
  - FULL: byte_r_o = 0. When the output register is empty, or is being consumed this cycle (!bit_v_o || bit_r_i), copy assembly to output and set bit_v_o = 1. Then go to DRAIN if asm_words == Dim*Dim, else to ASM.
  - DRAIN: byte_r_o = 0. When the final word transfers, go to DONE.
  - DONE: byte_r_o = 0, bit_v_o = 0, done_o = 1. Terminal until reset.
- Output register:
  - bit_v_o clears on a transfer unless the same edge reloads it from FULL.
  - bit_o holds its value while bit_v_o && !bit_r_i (no change under backpressure).
- word_cnt increments on each downstream transfer and saturates at Dim*Dim.
- last_o = bit_v_o && (word_cnt == Dim*Dim-1).
- byte_r_o is a function of registered state only. It has no combinational path from byte_v_i or bit_r_i.
- byte_v_i while byte_r_o = 0 is ignored: no state change, and the byte is not captured.

## Timing

- Reset (rst_ni low), effective immediately:
  - state = ASM; all counters 0.
  - Outputs: byte_r_o 0 while rst_ni is low, 1 from the first cycle after release. bit_o 0, bit_v_o 0, last_o 0, done_o 0, pad_err_o 0, word_cnt_o 0.
  - Any partial word in the assembly register is discarded.
- Latency: 10th byte accepted at edge N; the FULL-to-output copy happens at edge N+1 if the output register is free. bit_v_o is high starting the cycle after edge N+1.
- Throughput: at most one word per BPW+1 cycles. There is one dead input cycle per word (the FULL state).
- Simultaneous events: in FULL with bit_v_o && bit_r_i, the old word transfers and the new word loads on the same edge. bit_v_o stays 1 with no gap.
- The final word transfer sets done_o on the same edge. done_o is high the following cycle.

## Test plan

- Single word: bytes 0x01..0x0A with no gaps, bit_r_i = 1. Required:
  - bit_o = 77'h0A_09_08_07_06_05_04_03_02_01.
  - bit_v_o first high 2 cycles after the 10th byte is presented.
  - byte_r_o is 0 for exactly 1 cycle.
  - pad_err_o = 0.
- Backpressure: with bit_r_i = 0, stream 20 bytes. Required:
  - Word 0 held stable on bit_o.
  - Word 1 waits in FULL with byte_r_o = 0; the 21st byte is not accepted.
  - Raise bit_r_i: word 0 transfers, then word 1 appears on the next edge with no bit_v_o gap.
- Pad error: 10th byte = 0xFF. Required: bit_o[76:72] = 5'h1F, pad_err_o = 1 and it stays 1 through later clean words.
- Full run, Dim = 4: 160 bytes with random byte_v_i gaps and random bit_r_i. Required:
  - Exactly 16 words, all matching the model.
  - last_o only on the 16th word.
  - done_o = 1 and word_cnt_o = 16 afterward.
  - byte_r_o = 0 thereafter; extra byte_v_i pulses are ignored.
- Async reset mid-word: after 5 bytes, pulse rst_ni low between clock edges. Required: all outputs clear immediately. The next 10 bytes form a clean word with no leftover bytes.
- Reset mid-handshake: bit_v_o = 1, bit_r_i = 0, assert rst_ni low. Required: bit_v_o = 0 and word_cnt_o = 0 immediately.
